// File: rtl/alu_registers_pkg.sv
// Shared constants for the 8-bit CPU datapath: widths, opcode map,
// instruction field ranges, ALU function codes and control FSM states.
package alu_registers_pkg;

  localparam int unsigned WIDTH_WORD   = 8;
  localparam int unsigned WIDTH_SEG    = 4;
  localparam int unsigned WIDTH_DOUBLE = 16;
  localparam int unsigned NUM_REGS     = 1 << WIDTH_SEG;
  localparam int unsigned REG_PC_LO    = 14;
  localparam int unsigned REG_PC_HI    = 15;

  // Instruction field bit ranges
  localparam int unsigned ARG_OPC_HI  = 15;
  localparam int unsigned ARG_OPC_LO  = 12;
  localparam int unsigned ARG_DST_HI  = 11;
  localparam int unsigned ARG_DST_LO  = 8;
  localparam int unsigned ARG_SRC0_HI = 7;
  localparam int unsigned ARG_SRC0_LO = 4;
  localparam int unsigned ARG_SRC1_HI = 3;
  localparam int unsigned ARG_SRC1_LO = 0;
  localparam int unsigned ARG_NUM_HI  = 7;
  localparam int unsigned ARG_NUM_LO  = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_LD   = 4'b0001,
    OP_ST   = 4'b0010,
    OP_MVC  = 4'b0011,
    OP_CALL = 4'b0100,
    OP_MVD  = 4'b0101,
    OP_CND  = 4'b0110,
    OP_HLT  = 4'b0111,
    OP_ADD  = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_OR   = 4'b1010,
    OP_NOT  = 4'b1011,
    OP_MV   = 4'b1100,
    OP_EQ   = 4'b1101,
    OP_LT   = 4'b1110
  } opcode_e;

  // ALU function = opcode bits [14:12]
  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_SUB  = 3'b001,
    FN_OR   = 3'b010,
    FN_NOT  = 3'b011,
    FN_MV   = 3'b100,
    FN_EQ   = 3'b101,
    FN_LT   = 3'b110,
    FN_RSVD = 3'b111
  } alu_fn_e;

  typedef enum logic [2:0] {
    STATE_FETCHPC = 3'd0,
    STATE_FETCHOP = 3'd1,
    STATE_DECODE  = 3'd2,
    STATE_EXECUTE = 3'd3,
    STATE_STOREPC = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] dst;
    logic [3:0] src0;
    logic [3:0] src1;
  } instr_t;

endpackage

// File: rtl/alu_registers_alu.sv
// Combinational ALU: operands straight from the register read ports,
// function selected by opcode bits [14:12], gated by opcode bit 15.
module alu_registers_alu #(
  parameter int unsigned W = 8
) (
  input  logic         en,
  input  logic [2:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         carry
);
  import alu_registers_pkg::*;

  logic [W:0] sum;
  logic [W:0] diff;

  // Top bit of the widened difference is the borrow (a < b)
  always_comb begin
    out   = '0;
    carry = 1'b0;
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    if (en) begin
      case (alu_fn_e'(fn))
        FN_ADD: begin
          out   = sum[W-1:0];
          carry = sum[W];
        end
        FN_SUB: begin
          out   = diff[W-1:0];
          carry = diff[W];
        end
        FN_OR:   out = a | b;
        FN_NOT:  out = ~a;
        FN_MV:   out = a;
        FN_EQ:   out = W'(a == b);
        FN_LT:   out = W'(a < b);
        default: out = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_registers.sv
// CPU datapath core: 16 x 8 register file (two write, two read ports)
// feeding the combinational ALU. Registers 14/15 hold the PC.
module alu_registers #(
  parameter int unsigned WIDTH_WORD = 8,
  parameter int unsigned WIDTH_SEG  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write0,
  input  logic                  write1,
  input  logic [WIDTH_SEG-1:0]  dstreg0,
  input  logic [WIDTH_WORD-1:0] dstval0,
  input  logic [WIDTH_SEG-1:0]  dstreg1,
  input  logic [WIDTH_WORD-1:0] dstval1,
  input  logic [WIDTH_SEG-1:0]  argreg0,
  output logic [WIDTH_WORD-1:0] argval0,
  input  logic [WIDTH_SEG-1:0]  argreg1,
  output logic [WIDTH_WORD-1:0] argval1,
  input  logic                  alu_en,
  input  logic [2:0]            alu_fn,
  output logic [WIDTH_WORD-1:0] alu_out,
  output logic                  alu_carry
);
  import alu_registers_pkg::*;

  localparam int unsigned DEPTH = 1 << WIDTH_SEG;

  logic [WIDTH_WORD-1:0] regs [DEPTH];

  // Port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else begin
      if (write0) regs[dstreg0] <= dstval0;
      if (write1) regs[dstreg1] <= dstval1;
    end
  end

  assign argval0 = regs[argreg0];
  assign argval1 = regs[argreg1];

  alu_registers_alu #(.W(WIDTH_WORD)) u_alu (
    .en    (alu_en),
    .fn    (alu_fn),
    .a     (argval0),
    .b     (argval1),
    .out   (alu_out),
    .carry (alu_carry)
  );

endmodule

// File: tb/tb_alu_registers.sv
// Scoreboard bench for alu_registers: stimulus pushes expected read/ALU
// results from an array model; a negedge monitor pops and compares.
module tb_alu_registers;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write0 = 1'b0, write1 = 1'b0;
  logic [3:0] dstreg0 = '0, dstreg1 = '0, argreg0 = '0, argreg1 = '0;
  logic [7:0] dstval0 = '0, dstval1 = '0;
  logic [7:0] argval0, argval1, alu_out;
  logic       alu_en = 1'b0;
  logic [2:0] alu_fn = '0;
  logic       alu_carry;

  alu_registers dut (
    .clk(clk), .rst(rst),
    .write0(write0), .write1(write1),
    .dstreg0(dstreg0), .dstval0(dstval0),
    .dstreg1(dstreg1), .dstval1(dstval1),
    .argreg0(argreg0), .argval0(argval0),
    .argreg1(argreg1), .argval1(argval1),
    .alu_en(alu_en), .alu_fn(alu_fn),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] out;
    logic       c;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model [16];
  bit   stim_done = 1'b0;

  // Reference ALU from the opcode semantics, in integer arithmetic
  function automatic void ref_alu(input bit en, input int fn, input int a, input int b,
                                  output int out, output int c);
    out = 0; c = 0;
    if (en) begin
      case (fn)
        0: begin out = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
        1: begin out = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
        2: out = a | b;
        3: out = 255 - a;
        4: out = a;
        5: out = (a == b) ? 1 : 0;
        6: out = (a < b) ? 1 : 0;
        default: out = 0;
      endcase
    end
  endfunction

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Drive one cycle; called just after a rising edge
  task automatic step(input bit r, input bit w0, input int d0, input int v0,
                      input bit w1, input int d1, input int v1,
                      input int ra0, input int ra1, input bit en, input int fn,
                      input bit chk, input string name);
    exp_t e;
    int   o, c;
    rst = r; write0 = w0; dstreg0 = 4'(d0); dstval0 = 8'(v0);
    write1 = w1; dstreg1 = 4'(d1); dstval1 = 8'(v1);
    argreg0 = 4'(ra0); argreg1 = 4'(ra1); alu_en = en; alu_fn = 3'(fn);
    if (chk) begin
      ref_alu(en, fn, model[ra0], model[ra1], o, c);
      e.a0 = 8'(model[ra0]); e.a1 = 8'(model[ra1]);
      e.out = 8'(o); e.c = c[0]; e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      foreach (model[i]) model[i] = 0;
    end else begin
      if (w0) model[d0] = v0;
      if (w1) model[d1] = v1;
    end
    #1;
  endtask

  task automatic rd(input int ra0, input int ra1, input bit en, input int fn, input string name);
    step(0, 0, 0, 0, 0, 0, 0, ra0, ra1, en, fn, 1, name);
  endtask

  // Monitor: read ports and ALU settle mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".argval0"}, argval0, e.a0);
        check({e.name, ".argval1"}, argval1, e.a1);
        check({e.name, ".alu_out"}, alu_out, e.out);
        check({e.name, ".carry"}, alu_carry, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1;
    foreach (model[i]) model[i] = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "init");
    // Reset clears a written register, and every register reads 0
    step(0, 1, 5, 8'hAA, 0, 0, 0, 5, 5, 0, 0, 1, "pre_rst");
    rd(5, 5, 0, 0, "written5");
    step(1, 1, 6, 8'h33, 0, 0, 0, 5, 5, 0, 0, 1, "rst_cycle");
    for (int i = 0; i < 8; i++) rd(2 * i, 2 * i + 1, 0, 0, "after_rst");
    // Dual write then ADD, result written back to reg2
    step(0, 1, 1, 8, 1, 3, 5, 0, 0, 0, 0, 1, "dual_wr");
    rd(3, 1, 0, 0, "dual_rd");
    rd(3, 1, 1, 0, "add_5_8");
    step(0, 1, 2, 13, 0, 0, 0, 3, 1, 1, 0, 1, "wb_reg2");
    rd(2, 2, 0, 0, "reg2_13");
    // Collision: port 1 wins, then hold
    step(0, 1, 7, 8'h11, 1, 7, 8'h22, 7, 7, 0, 0, 1, "collide");
    rd(7, 7, 0, 0, "coll_rd");
    rd(7, 0, 1, 4, "coll_hold");
    // PC pair in regs 14/15, then PC+2 with low-byte wrap
    step(0, 1, 14, 8'hFE, 1, 15, 8'h00, 14, 15, 0, 0, 1, "pc_wr");
    rd(14, 15, 0, 0, "pc_00fe");
    step(0, 1, 14, 8'h00, 1, 15, 8'h01, 14, 15, 1, 0, 1, "pc_inc");
    rd(14, 15, 0, 0, "pc_0100");
    // ALU edge cases
    step(0, 1, 8, 8'hFF, 1, 9, 8'h01, 0, 0, 0, 0, 1, "ld_ff_01");
    rd(8, 9, 1, 0, "add_ovf");
    step(0, 1, 8, 8'h03, 1, 9, 8'h05, 0, 0, 0, 0, 1, "ld_03_05");
    rd(8, 9, 1, 1, "sub_brw");
    step(0, 1, 10, 8'h0F, 1, 11, 9, 0, 0, 0, 0, 1, "ld_0f_09");
    rd(10, 0, 1, 3, "not_0f");
    rd(11, 11, 1, 5, "eq_9_9");
    step(0, 1, 12, 3, 0, 0, 0, 0, 0, 0, 0, 1, "ld_3");
    rd(11, 12, 1, 6, "lt_9_3");
    rd(12, 11, 1, 6, "lt_3_9");
    rd(8, 9, 0, 0, "alu_off");
    rd(8, 9, 1, 7, "rsvd");
    rd(10, 11, 1, 2, "or");
    // Read timing: old value visible until the edge
    step(0, 1, 4, 8'h5A, 0, 0, 0, 4, 4, 0, 0, 1, "rt_old");
    rd(4, 4, 0, 0, "rt_new");
    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      s0 = $urandom_range(15); s1 = $urandom_range(15);
      step(($urandom_range(49) == 0),
           $urandom_range(1), s0, $urandom_range(255),
           $urandom_range(1), ($urandom_range(3) == 0) ? s0 : s1, $urandom_range(255),
           $urandom_range(15), $urandom_range(15),
           $urandom_range(3) != 0, $urandom_range(7), 1, "rand");
    end
    rst = 1'b0; write0 = 1'b0; write1 = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_registers.md
Name: alu_registers

Overview:
- Datapath core of the 8-bit CPU: a 16 x 8-bit register file plus a combinational ALU.
- The register file has two synchronous write ports and two combinational read ports.
- The ALU's operands come from the two read ports. The control FSM drives its mode/function from opcode bits [15:12].
- Registers 14 (low) and 15 (high) hold the 16-bit program counter. Register 14 is read on port 0 and register 15 on port 1, giving PC = {argval1, argval0}.

Parameters:
- WIDTH_WORD, 8, data word width.
- WIDTH_SEG, 4, register index width; 2**WIDTH_SEG registers.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- write0  in  1  write enable, port 0.
- write1  in  1  write enable, port 1.
- dstreg0  in  WIDTH_SEG  write address, port 0.
- dstval0  in  WIDTH_WORD  write data, port 0.
- dstreg1  in  WIDTH_SEG  write address, port 1.
- dstval1  in  WIDTH_WORD  write data, port 1.
- argreg0  in  WIDTH_SEG  read address, port 0.
- argval0  out  WIDTH_WORD  read data, port 0; also ALU operand A.
- argreg1  in  WIDTH_SEG  read address, port 1.
- argval1  out  WIDTH_WORD  read data, port 1; also ALU operand B.
- alu_en  in  1  ALU mode bit (opcode bit 15).
- alu_fn  in  3  ALU function (opcode bits 14:12).
- alu_out  out  WIDTH_WORD  ALU result.
- alu_carry  out  1  ALU carry/borrow.

Behaviour:
- Reset: on a rising edge with rst=1, all 16 registers become 0; writes in that cycle are ignored. PC therefore restarts at 0.
- Write timing: on a rising edge with rst=0, if writeN=1 then reg[dstregN] <= dstvalN. The new value is visible on reads the cycle after the edge.
- Collision: if both ports are enabled with the same address, port 1 wins.
- No write protection: registers 14 and 15 are ordinary and writable by either port.
- Reads: argvalN = reg[argregN], purely combinational, reflecting the current stored contents. There is no write-through bypass of same-edge writes.
- ALU: purely combinational, A = argval0, B = argval1, computed on the current read data.
- alu_en=0: alu_out=0, alu_carry=0 (non-ALU opcodes).
- alu_en=1, by alu_fn:
  - 000 ADD: {carry,out} = A+B (9-bit sum).
  - 001 SUB: out = A-B mod 256; carry = (A<B), i.e. borrow.
  - 010 OR: out = A|B, carry 0.
  - 011 NOT: out = ~A, carry 0.
  - 100 MV: out = A, carry 0.
  - 101 EQ: out = (A==B) ? 1 : 0, carry 0.
  - 110 LT: out = (A<B) ? 1 : 0, unsigned, carry 0.
  - 111 reserved: out 0, carry 0.
- Opcode map (4-bit, bits 15:12): NOP=0000, LD=0001, ST=0010, MVC=0011, CALL=0100, MVD=0101, CND=0110, HLT=0111, ADD=1000, SUB=1001, OR=1010, NOT=1011, MV=1100, EQ=1101, LT=1110.
- Instruction fields: OPC=[15:12], DST=[11:8], SRC0=[7:4], SRC1=[3:0], NUM=[7:0].
- Control FSM states: FETCHPC, FETCHOP, DECODE, EXECUTE, STOREPC. The FSM is outside this block.

Decomposition:
- Shared package/include (const): WIDTH_WORD=8, WIDTH_SEG=4, WIDTH_DOUBLE=16, all OP_* codes, ARG_* field ranges, STATE_* codes.
- Sub-module "alu": combinational, ports (en, fn[2:0], a, b, out, carry), instantiated inside alu_registers.
- The register array stays in the top of this block.

Test Plan:
- Reset: write reg5=0xAA, assert rst one cycle -> argval0 (argreg0=5)=0x00. Both read ports return 0 for every address after reset.
- Dual write: write0 reg1=8 and write1 reg3=5 in the same cycle -> next cycle argreg0=3, argreg1=1 reads 5 and 8. Then alu_en=1, alu_fn=000 -> alu_out=13, carry=0. Write alu_out to reg2 -> reg2 reads 13.
- Collision: write0 and write1 both to reg7, values 0x11 and 0x22 -> reg7=0x22. With write0=write1=0, reg7 is held.
- PC pair: write reg14=0xFE, reg15=0x00 -> {argval1,argval0}=0x00FE. Writing PC+2 (0x0100) -> 0x0100, low-byte wrap carries correctly.
- ALU edge cases:
  - ADD 0xFF+0x01 -> out 0x00, carry 1.
  - SUB 0x03-0x05 -> 0xFE, carry 1.
  - NOT 0x0F -> 0xF0.
  - EQ 9,9 -> 1.
  - LT 9,3 -> 0.
  - alu_en=0 -> out 0, carry 0.
- Read timing: write reg4=0x5A while argreg0=4 -> argval0 shows the old value until the edge, then 0x5A.
